// File: rtl/gba_vram_arb_pkg.sv
// Shared constants and types for the VRAM drawer arbiter.
// Client indices, default sizes and the in-flight read tag layout.
package gba_vram_arb_pkg;

  localparam int NUM_REQ_DEF = 5;
  localparam int VRAM_ADDR_W = 14;
  localparam int ARB_ID_W    = $clog2(NUM_REQ_DEF);

  localparam logic [ARB_ID_W-1:0] ARB_BG0 = ARB_ID_W'(0);
  localparam logic [ARB_ID_W-1:0] ARB_BG1 = ARB_ID_W'(1);
  localparam logic [ARB_ID_W-1:0] ARB_BG2 = ARB_ID_W'(2);
  localparam logic [ARB_ID_W-1:0] ARB_BG3 = ARB_ID_W'(3);
  localparam logic [ARB_ID_W-1:0] ARB_OBJ = ARB_ID_W'(4);

  // One entry per read slot, travels alongside the VRAM pipeline.
  typedef struct packed {
    logic                vld;
    logic [ARB_ID_W-1:0] id;
  } arb_tag_t;

endpackage

// File: rtl/gba_arb_picker.sv
// Combinational client picker for the VRAM drawer arbiter.
// rotate=0: lowest eligible index wins. rotate=1: search starts at ptr
// and wraps, giving round-robin when ptr follows the last grant.
module gba_arb_picker
  import gba_vram_arb_pkg::*;
#(
  parameter int N    = NUM_REQ_DEF,
  parameter int ID_W = ARB_ID_W
) (
  input  logic [N-1:0]    eligible,
  input  logic [ID_W-1:0] ptr,
  input  logic            rotate,
  output logic            grant_valid,
  output logic [ID_W-1:0] grant_id
);

  // First eligible client in search order wins
  always_comb begin : pick_search
    int idx_v;
    idx_v       = 0;
    grant_valid = 1'b0;
    grant_id    = '0;
    for (int k = 0; k < N; k++) begin
      if (rotate) begin
        idx_v = int'(ptr) + k;
        if (idx_v >= N) begin
          idx_v = idx_v - N;
        end else begin
          idx_v = idx_v;
        end
      end else begin
        idx_v = k;
      end
      if (!grant_valid && eligible[idx_v]) begin
        grant_valid = 1'b1;
        grant_id    = ID_W'(idx_v);
      end else begin
        grant_valid = grant_valid;
      end
    end
  end

endmodule

// File: rtl/gba_vram_drawer_arbiter.sv
// VRAM read-port arbiter shared by the BG0-3 and OBJ drawers.
// One read per cycle; each read carries a requester tag down a shift
// register aligned with the VRAM latency so the returned word is routed
// back with a one-cycle valid to the right client.
// Optional macro GBA_VRAMARB_RR_EN selects round-robin arbitration;
// without it arbitration is fixed priority (BG0 highest).
module gba_vram_drawer_arbiter
  import gba_vram_arb_pkg::*;
#(
  parameter int NUM_REQ    = NUM_REQ_DEF,
  parameter int ADDR_W     = VRAM_ADDR_W,
  parameter int RD_LATENCY = 2
) (
  input  logic                      fclk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        valid,
  output logic [31:0]               rdata,
  output logic                      mem_ce,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic [31:0]               mem_data,
  output logic                      busy
);

  localparam int ID_W = ARB_ID_W;

`ifdef GBA_VRAMARB_RR_EN
  localparam logic ROTATE = 1'b1;
`else
  localparam logic ROTATE = 1'b0;
`endif

  logic [NUM_REQ-1:0] pending_r;
  logic [NUM_REQ-1:0] valid_r;
  logic [31:0]        rdata_r;
  logic               mem_ce_r;
  logic [ADDR_W-1:0]  mem_addr_r;
  logic               busy_r;
  arb_tag_t           tag_pipe_r [RD_LATENCY];

  logic [NUM_REQ-1:0] eligible_s;
  logic [NUM_REQ-1:0] pending_nxt_s;
  logic [NUM_REQ-1:0] valid_nxt_s;
  logic [ADDR_W-1:0]  grant_addr_s;
  logic               grant_valid_s;
  logic [ID_W-1:0]    grant_id_s;
  logic [ID_W-1:0]    ptr_s;
  arb_tag_t           tail_s;
  arb_tag_t           push_s;

`ifdef GBA_VRAMARB_RR_EN
  logic [ID_W-1:0] ptr_r;

  // Round-robin pointer moves just past the client granted this cycle
  always_ff @(posedge fclk) begin
    if (reset) begin
      ptr_r <= '0;
    end else if (grant_valid_s) begin
      ptr_r <= (grant_id_s == ID_W'(NUM_REQ - 1)) ? ID_W'(0) : grant_id_s + ID_W'(1);
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign ptr_s = ptr_r;
`else
  assign ptr_s = '0;
`endif

  // A client whose data is on the bus this cycle still holds its old
  // address, so it is kept out of arbitration until the next cycle.
  assign eligible_s = req & ~pending_r & ~valid_r;
  assign tail_s     = tag_pipe_r[RD_LATENCY-1];

  gba_arb_picker #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_picker (
    .eligible    (eligible_s),
    .ptr         (ptr_s),
    .rotate      (ROTATE),
    .grant_valid (grant_valid_s),
    .grant_id    (grant_id_s)
  );

  // Next pending mask, return pulse, new tag and granted address
  always_comb begin
    pending_nxt_s = pending_r;
    valid_nxt_s   = '0;
    grant_addr_s  = req_addr[int'(grant_id_s)*ADDR_W +: ADDR_W];
    push_s.vld    = grant_valid_s;
    push_s.id     = grant_valid_s ? grant_id_s : ID_W'(0);
    if (tail_s.vld) begin
      pending_nxt_s[tail_s.id] = 1'b0;
      valid_nxt_s[tail_s.id]   = 1'b1;
    end else begin
      valid_nxt_s = '0;
    end
    // A granted client cannot also be returning: its pending bit was clear.
    if (grant_valid_s) begin
      pending_nxt_s[grant_id_s] = 1'b1;
    end else begin
      pending_nxt_s = pending_nxt_s;
    end
  end

  // Registered VRAM strobe, returns, pending state and tag pipeline
  always_ff @(posedge fclk) begin
    if (reset) begin
      pending_r  <= '0;
      valid_r    <= '0;
      rdata_r    <= 32'h0000_0000;
      mem_ce_r   <= 1'b0;
      mem_addr_r <= '0;
      busy_r     <= 1'b0;
      for (int k = 0; k < RD_LATENCY; k++) begin
        tag_pipe_r[k] <= '0;
      end
    end else begin
      pending_r  <= pending_nxt_s;
      valid_r    <= valid_nxt_s;
      busy_r     <= |pending_nxt_s;
      rdata_r    <= tail_s.vld ? mem_data : rdata_r;
      mem_ce_r   <= grant_valid_s;
      mem_addr_r <= grant_valid_s ? grant_addr_s : mem_addr_r;
      tag_pipe_r[0] <= push_s;
      for (int k = 1; k < RD_LATENCY; k++) begin
        tag_pipe_r[k] <= tag_pipe_r[k-1];
      end
    end
  end

  assign valid    = valid_r;
  assign rdata    = rdata_r;
  assign mem_ce   = mem_ce_r;
  assign mem_addr = mem_addr_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_gba_vram_drawer_arbiter.sv
// Self-checking bench for gba_vram_drawer_arbiter: a cycle-indexed
// behavioural model plus directed scenarios with literal expectations.
module tb_gba_vram_drawer_arbiter;

  localparam int NR     = 5;
  localparam int AW     = 14;
  localparam int LAT    = 2;
  localparam int MAXC   = 4096;
  localparam int AP_IDX = (LAT >= 2) ? LAT - 2 : 0;

  logic              fclk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req;
  logic [NR*AW-1:0]  req_addr;
  logic [NR-1:0]     valid;
  logic [31:0]       rdata;
  logic              mem_ce;
  logic [AW-1:0]     mem_addr;
  logic [31:0]       mem_data;
  logic              busy;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 fclk = ~fclk;

  gba_vram_drawer_arbiter #(
    .NUM_REQ    (NR),
    .ADDR_W     (AW),
    .RD_LATENCY (LAT)
  ) dut (
    .fclk     (fclk),
    .reset    (reset),
    .req      (req),
    .req_addr (req_addr),
    .valid    (valid),
    .rdata    (rdata),
    .mem_ce   (mem_ce),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .busy     (busy)
  );

  // VRAM: data for an address presented while mem_ce is high appears LAT-1 cycles later
  logic [31:0]   vmem [0:16383];
  logic [AW-1:0] ap [0:3];

  always @(posedge fclk) begin
    ap[0] <= mem_addr;
    for (int k = 1; k < 4; k++) ap[k] <= ap[k-1];
  end

  assign mem_data = vmem[(LAT == 1) ? mem_addr : ap[AP_IDX]];

  // Model state, indexed by absolute cycle number
  int            cyc;
  int            free_at [NR];
  int            pend_lo [NR];
  int            pend_hi [NR];
  int            ptr_m;
  int            ev_id   [0:MAXC-1];
  logic [31:0]   ev_data [0:MAXC-1];
  logic          m_ce;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_rdata;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: per rising edge decide the grant and schedule its effects
  initial begin
    cyc = 0;
    ptr_m = 0;
    m_ce = 1'b0;
    m_addr = '0;
    m_rdata = 32'h0;
    for (int k = 0; k < MAXC; k++) begin
      ev_id[k] = -1;
      ev_data[k] = 32'h0;
    end
    for (int i = 0; i < NR; i++) begin
      free_at[i] = 0;
      pend_lo[i] = 0;
      pend_hi[i] = -1;
    end
    forever begin
      @(posedge fclk);
      if (reset) begin
        for (int k = cyc + 1; k < MAXC; k++) ev_id[k] = -1;
        for (int i = 0; i < NR; i++) begin
          free_at[i] = 0;
          pend_hi[i] = -1;
        end
        ptr_m = 0;
        m_ce = 1'b0;
        m_addr = '0;
        m_rdata = 32'h0;
      end else begin
        int g;
        g = -1;
        for (int k = 0; k < NR; k++) begin
          int i;
`ifdef GBA_VRAMARB_RR_EN
          i = (ptr_m + k) % NR;
`else
          i = k;
`endif
          if (g < 0 && req[i] && cyc >= free_at[i]) g = i;
        end
        if (g >= 0) begin
          // a client is reissued no sooner than LAT+2 cycles after its grant
          free_at[g] = cyc + LAT + 2;
          pend_lo[g] = cyc + 1;
          pend_hi[g] = cyc + LAT;
          m_ce = 1'b1;
          m_addr = req_addr[g*AW +: AW];
          if (cyc + LAT + 1 < MAXC) begin
            ev_id[cyc + LAT + 1] = g;
            ev_data[cyc + LAT + 1] = vmem[m_addr];
          end
          ptr_m = (g + 1) % NR;
        end else begin
          m_ce = 1'b0;
        end
        if (cyc + 1 < MAXC && ev_id[cyc + 1] >= 0) m_rdata = ev_data[cyc + 1];
      end
      cyc++;
    end
  end

  // Compare every DUT output against the model on each falling edge
  initial begin
    forever begin
      @(negedge fclk);
      if (chk_en && cyc < MAXC) begin
        logic [NR-1:0] ev;
        logic          eb;
        ev = (ev_id[cyc] >= 0) ? (NR'(1) << ev_id[cyc]) : '0;
        eb = 1'b0;
        for (int i = 0; i < NR; i++)
          if (cyc >= pend_lo[i] && cyc <= pend_hi[i]) eb = 1'b1;
        check("valid",    32'(valid),    32'(ev));
        check("rdata",    rdata,         m_rdata);
        check("mem_ce",   32'(mem_ce),   32'(m_ce));
        check("mem_addr", 32'(mem_addr), 32'(m_addr));
        check("busy",     32'(busy),     32'(eb));
      end
    end
  end

  task automatic set_req(input int i, input logic [AW-1:0] a);
    req[i] = 1'b1;
    req_addr[i*AW +: AW] = a;
  endtask

  int ce_cnt;
  int gq[$];

  // Directed scenarios
  initial begin
    for (int a = 0; a < 16384; a++) vmem[a] = 32'hC0DE_0000 | 32'(a);
    reset = 1'b1;
    req = '0;
    req_addr = '0;
    repeat (2) @(negedge fclk);
    reset = 1'b0;
    chk_en = 1'b1;

    // Reset state
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_busy",  32'(busy),  32'h0);
    check("rst_ce",    32'(mem_ce), 32'h0);
    check("rst_addr",  32'(mem_addr), 32'h0);

    // Single client
    @(negedge fclk);
    vmem[14'h0123] = 32'hDEAD_BEEF;
    set_req(2, 14'h0123);
    ce_cnt = 0;
    @(negedge fclk);
    check("sc_addr", 32'(mem_addr), 32'h0000_0123);
    check("sc_ce",   32'(mem_ce),   32'h1);
    ce_cnt += int'(mem_ce);
    repeat (LAT) begin
      @(negedge fclk);
      ce_cnt += int'(mem_ce);
    end
    check("sc_valid", 32'(valid), 32'h0000_0004);
    check("sc_rdata", rdata, 32'hDEAD_BEEF);
    check("sc_one_ce", 32'(ce_cnt), 32'h1);
    req[2] = 1'b0;
    repeat (4) @(negedge fclk);

    // All five requesting continuously
    for (int i = 0; i < NR; i++) set_req(i, AW'(14'h0010 + i));
    gq.delete();
    repeat (24) begin
      @(negedge fclk);
      if (mem_ce) gq.push_back(int'(mem_addr) - 16);
    end
    req = '0;
    check("all_ngrants", 32'(gq.size() >= 5), 32'h1);
    if (gq.size() >= 5) begin
      check("all_g0", 32'(gq[0]), 32'h0);
      check("all_g1", 32'(gq[1]), 32'h1);
      check("all_g2", 32'(gq[2]), 32'h2);
      check("all_g3", 32'(gq[3]), 32'h3);
`ifdef GBA_VRAMARB_RR_EN
      check("all_g4", 32'(gq[4]), 32'h4);
`endif
    end
    repeat (LAT + 4) @(negedge fclk);

    // Pipelined returns from consecutive grants
    vmem[14'h00A0] = 32'h0000_000A;
    vmem[14'h00B0] = 32'h0000_000B;
    set_req(0, 14'h00A0);
    set_req(1, 14'h00B0);
    repeat (LAT + 1) @(negedge fclk);
    check("pl_valid0", 32'(valid), 32'h0000_0001);
    check("pl_rdata0", rdata, 32'h0000_000A);
    req[0] = 1'b0;
    @(negedge fclk);
    check("pl_valid1", 32'(valid), 32'h0000_0002);
    check("pl_rdata1", rdata, 32'h0000_000B);
    req[1] = 1'b0;
    repeat (4) @(negedge fclk);

    // Request dropped while in flight
    set_req(3, 14'h0333);
    @(negedge fclk);
    req[3] = 1'b0;
    check("drop_busy", 32'(busy), 32'h1);
    repeat (LAT) @(negedge fclk);
    check("drop_valid", 32'(valid), 32'h0000_0008);
    check("drop_rdata", rdata, 32'hC0DE_0333);
    check("drop_idle",  32'(busy), 32'h0);
    repeat (3) @(negedge fclk);

    // Reset while two reads are in flight
    set_req(0, 14'h0050);
    set_req(1, 14'h0051);
    repeat (2) @(negedge fclk);
    reset = 1'b1;
    req = '0;
    @(negedge fclk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("rst_fl_valid", 32'(valid), 32'h0);
      check("rst_fl_busy",  32'(busy),  32'h0);
      @(negedge fclk);
    end
    set_req(4, 14'h0444);
    repeat (LAT + 1) @(negedge fclk);
    check("post_valid", 32'(valid), 32'h0000_0010);
    check("post_rdata", rdata, 32'hC0DE_0444);
    req[4] = 1'b0;
    repeat (5) @(negedge fclk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gba_vram_drawer_arbiter.md
Name: gba_vram_drawer_arbiter

Overview:
- Shares one VRAM read port (32-bit word, pipelined, fixed latency) between NUM_REQ drawer clients: BG0-3 tile/affine/bitmap drawers and the OBJ drawer.
- Each client holds its word address and a request until it receives a one-cycle valid, which is the drawer-side handshake already used by the drawers.
- Issues at most one memory read per cycle.
- Tracks every in-flight read with a requester tag and routes the returned data back with a per-client valid pulse.

Parameters:
- NUM_REQ, 5, number of drawer clients (index 0 = BG0 ... 4 = OBJ).
- ADDR_W, 14, VRAM word-address width.
- RD_LATENCY, 2, cycles from mem_addr/mem_ce sample to mem_data valid (1..4).

Ports:
- fclk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-client read request, level.
- req_addr  in  NUM_REQ*ADDR_W  packed word addresses; client i uses slice [i*ADDR_W +: ADDR_W].
- valid  out  NUM_REQ  one-cycle pulse when data for client i is on rdata.
- rdata  out  32  returned word, shared by all clients.
- mem_ce  out  1  read strobe to VRAM.
- mem_addr  out  ADDR_W  read address to VRAM.
- mem_data  in  32  VRAM read data, valid RD_LATENCY cycles after mem_ce.
- busy  out  1  high while any read is in flight.

Behaviour:
- Reset values: valid=0, rdata=0, mem_ce=0, mem_addr=0, busy=0; pending mask, tag pipeline and RR pointer all cleared.
- Client contract: assert req with a stable req_addr; hold both until valid[i] is seen; deassert or change the address in the cycle after valid[i].
- Eligibility per cycle: req[i]=1 AND pending[i]=0. Pending is set on grant and cleared on return.
- Grant, cycle N:
  - pick one eligible client; registered outputs mem_ce=1, mem_addr=req_addr[i] in cycle N+1;
  - set pending[i];
  - push tag {vld=1, id=i} into a RD_LATENCY-deep shift register aligned to mem_data.
- No eligible client: mem_ce=0, mem_addr holds its last value, and a {vld=0} tag is pushed.
- Return: when the tag at the pipeline tail has vld=1:
  - register rdata <= mem_data;
  - valid[id] <= 1 for one cycle;
  - clear pending[id].
- Latency: request sampled in N; mem_ce in N+1; valid in N+1+RD_LATENCY. Read-to-valid is 3 cycles at the default latency.
- Throughput: one read per cycle aggregate. A single client gets at most one outstanding read, so its back-to-back rate is 1 per (RD_LATENCY+2) cycles.
- Same-cycle return and request by a client: pending is cleared by the return and that client becomes eligible the following cycle, not the same cycle. This prevents reissuing a stale address.
- Request dropped while in flight: the read completes, valid still pulses and pending clears; the client ignores it. No cancellation logic.
- busy = (pending != 0).
- Reset asserted mid-operation clears all in-flight tags. No valid is emitted for reads issued before reset, even if mem_data returns afterwards.
- Arbitration without the optional feature: fixed priority, lowest index wins (BG0 highest, OBJ lowest).

Optional Feature:
- Macro GBA_VRAMARB_RR_EN.
- Defined: round-robin arbitration. The pointer starts at 0; the search starts at the pointer. After a grant to i, pointer <= (i+1) mod NUM_REQ. With no grant, the pointer holds.
- Not defined: fixed priority as above, and no pointer register exists.

Decomposition:
- Package gba_vram_arb_pkg holds NUM_REQ_DEF=5, VRAM_ADDR_W=14, client index constants (ARB_BG0..ARB_BG3, ARB_OBJ), and the tag struct type {vld, id[$clog2(NUM_REQ)-1:0]}.
- One sub-module, gba_arb_picker: combinational picker with inputs eligible mask and pointer, outputs grant_valid and grant_id. It supports both fixed-priority and rotating search, selected by a port tied from the macro.

Test Plan:
- Single client: req[2]=1, addr=0x0123; mem model returns 0xDEADBEEF. Required:
  - mem_addr=0x0123 one cycle later;
  - valid=5'b00100 exactly 3 cycles after the req sample;
  - rdata=0xDEADBEEF;
  - no second mem_ce while req is held before valid.
- All 5 requesting continuously, addresses 0x10+i:
  - Fixed priority: client 0 is reissued as soon as it is eligible again (every RD_LATENCY+2 cycles); clients fill the idle slots in index order.
  - With GBA_VRAMARB_RR_EN: grant order 0,1,2,3,4,0,... and each client is served once per 5 grants.
- Pipelined returns: clients 0 and 1 are granted on consecutive cycles with mem data 0xA and 0xB. Required: valid[0] with 0xA, then valid[1] with 0xB on the next cycle; no tag swap.
- Request drop: client 3 deasserts req one cycle after grant. Required: valid[3] still pulses; pending[3] and busy clear afterwards.
- Reset mid-flight: reset for 1 cycle while 2 reads are in flight. Required: valid stays 0 for the next 4 cycles; busy=0; a subsequent req from client 4 completes normally.
- RD_LATENCY=4 build: same as the single-client scenario with valid at 5 cycles after the req sample.
